// File: rtl/axis_frame_streamer.sv
// AXI-Stream frame generator (ramp/constant/LFSR) with backpressure and
// programmable idle gaps, plus a never-stalling sink that checks returned frames.
//
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   start_i               : 1-cycle pulse, begins a transfer when idle
//   mode_i/seed_i/gap_i   : pattern, seed/constant, idle cycles per beat
//   num_frames_i          : frames per start (0 means 1)
//   m_axis_*              : generated stream (tuser = first, tlast = last)
//   s_axis_*              : returned stream, tready tied high
//   busy_o, done_o        : generator active, 1-cycle completion pulse
//   rx_frames_o           : returned frames (tlast beats)
//   checksum_o            : sum of returned tdata
//   err_len_o             : sticky, a returned frame had length != OUT_BEATS
module axis_frame_streamer #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int CHANNELS  = 1,
  parameter int OUT_BEATS = 676
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [15:0]       seed_i,
  input  logic [7:0]        gap_i,
  input  logic [7:0]        num_frames_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       rx_frames_o,
  output logic [31:0]       checksum_o,
  output logic              err_len_o
);

  localparam int FRAME_BEATS = IMG_W * IMG_H * CHANNELS;
  localparam int PW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(
    input logic [1:0]    mode,
    input logic [PW-1:0] p,
    input logic [15:0]   seed,
    input logic [15:0]   l
  );
    case (mode)
      2'b01:   return seed[DATA_W-1:0];
      2'b10:   return l[DATA_W-1:0];
      default: return DATA_W'(p);
    endcase
  endfunction

  state_t            r_state;
  logic [PW-1:0]     r_p;
  logic [7:0]        r_frame;
  logic [7:0]        r_nframes;
  logic [7:0]        r_gap;
  logic [7:0]        r_gcnt;
  logic [1:0]        r_mode;
  logic [15:0]       r_seed;
  logic [15:0]       r_lfsr;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_tuser;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_rx_cnt;
  logic [15:0]       r_rx_frames;
  logic [31:0]       r_csum;
  logic              r_err;

  logic          w_hs;
  logic          w_last;
  logic [PW-1:0] w_p_nxt;
  logic [7:0]    w_frame_nxt;
  logic          w_final;
  logic [15:0]   w_lfsr_nxt;
  logic [15:0]   w_seed0;
  logic [16:0]   w_rx_len;

  assign w_hs        = r_tvalid & m_axis_tready;
  assign w_last      = (r_p == P_LAST);
  assign w_p_nxt     = w_last ? '0 : r_p + 1'b1;
  assign w_frame_nxt = r_frame + 8'd1;
  assign w_final     = w_last && (w_frame_nxt == r_nframes);
  assign w_lfsr_nxt  = lfsr_step(r_lfsr);
  assign w_seed0     = (seed_i == 16'h0) ? 16'h1 : seed_i;
  assign w_rx_len    = {1'b0, r_rx_cnt} + 17'd1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_frame   <= '0;
      r_nframes <= '0;
      r_gap     <= '0;
      r_gcnt    <= '0;
      r_mode    <= '0;
      r_seed    <= '0;
      r_lfsr    <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_SEND;
            r_p       <= '0;
            r_frame   <= '0;
            r_nframes <= (num_frames_i == 8'd0) ? 8'd1 : num_frames_i;
            r_gap     <= gap_i;
            r_mode    <= mode_i;
            r_seed    <= seed_i;
            r_lfsr    <= w_seed0;
            r_tdata   <= beat_data(mode_i, '0, seed_i, w_seed0);
            r_tvalid  <= 1'b1;
            r_tuser   <= 1'b1;
            r_tlast   <= (FRAME_BEATS == 1);
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_p     <= w_p_nxt;
            r_lfsr  <= w_lfsr_nxt;
            if (w_last) r_frame <= w_frame_nxt;
            if (w_final) begin
              r_state  <= S_DONE;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_tuser  <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              // next beat is staged now; GAP only hides it
              r_tdata <= beat_data(r_mode, w_p_nxt, r_seed, w_lfsr_nxt);
              r_tuser <= (w_p_nxt == '0);
              r_tlast <= (w_p_nxt == P_LAST);
              if (r_gap != 8'd0) begin
                r_state  <= S_GAP;
                r_tvalid <= 1'b0;
                r_gcnt   <= r_gap;
              end
            end
          end
        end
        S_GAP: begin
          if (r_gcnt == 8'd1) begin
            r_state  <= S_SEND;
            r_tvalid <= 1'b1;
          end
          r_gcnt <= r_gcnt - 8'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_cnt    <= '0;
      r_rx_frames <= '0;
      r_csum      <= '0;
      r_err       <= 1'b0;
    end else if (s_axis_tvalid) begin
      r_csum <= r_csum + 32'(s_axis_tdata);
      if (s_axis_tlast) begin
        if (w_rx_len != 17'(OUT_BEATS)) r_err <= 1'b1;
        r_rx_cnt    <= '0;
        r_rx_frames <= r_rx_frames + 16'd1;
      end else if (r_rx_cnt != 16'hFFFF) begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign s_axis_tready = 1'b1;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign rx_frames_o   = r_rx_frames;
  assign checksum_o    = r_csum;
  assign err_len_o     = r_err;

endmodule

// File: tb/tb_axis_frame_streamer.sv
// Randomized self-checking bench for axis_frame_streamer (4x4x1 frames).
// Expected beats come from a queue built with plain arithmetic.
module tb_axis_frame_streamer;

  localparam int DW = 8;
  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [15:0]   seed_i;
  logic [7:0]    gap_i;
  logic [7:0]    num_frames_i;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   rx_frames_o;
  logic [31:0]   checksum_o;
  logic          err_len_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_frame_streamer #(
    .DATA_W(DW), .IMG_W(4), .IMG_H(4),
    .CHANNELS(1), .OUT_BEATS(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .mode_i(mode_i), .seed_i(seed_i), .gap_i(gap_i),
    .num_frames_i(num_frames_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .busy_o(busy_o), .done_o(done_o), .rx_frames_o(rx_frames_o),
    .checksum_o(checksum_o), .err_len_o(err_len_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // rmode: 0 always ready, 1 stall 3 cycles at beats 3 and 9, 2 random
  task automatic run_xfer(input logic [1:0] mode, input logic [15:0] seed,
                          input logic [7:0] gap, input logic [7:0] nf,
                          input int rmode, input bit start_in_done);
    logic [DW+1:0] q[$];
    logic [DW+1:0] cur, pd;
    logic [15:0]   l;
    logic [DW-1:0] d;
    int nfe, total, p, cyc, idle, hold, sent, last_cyc;
    bit pv, pr, tr, need_gap, st3, st9;
    nfe = (nf == 0) ? 1 : int'(nf);
    l = (seed == 0) ? 16'h1 : seed;
    for (int k = 0; k < nfe * FB; k++) begin
      p = k % FB;
      case (mode)
        2'b01:   d = seed[DW-1:0];
        2'b10:   d = l[DW-1:0];
        default: d = DW'(p);
      endcase
      l = lstep(l);
      q.push_back({p == FB - 1, p == 0, d});
    end
    total = q.size();
    @(negedge clk);
    mode_i = mode; seed_i = seed; gap_i = gap;
    num_frames_i = nf; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("latency", {busy_o, m_axis_tvalid}, 2'b11);
    cyc = 0; idle = 0; hold = 0; sent = 0; last_cyc = 0;
    pv = 0; pr = 0; pd = '0; need_gap = 0; st3 = 0; st9 = 0;
    while (q.size() > 0 && cyc < 20000) begin
      case (rmode)
        0: tr = 1'b1;
        1: begin
          if (hold > 0) begin
            tr = 1'b0; hold--;
          end else if (m_axis_tvalid &&
                       ((sent == 3 && !st3) || (sent == 9 && !st9))) begin
            if (sent == 3) st3 = 1; else st9 = 1;
            hold = 2; tr = 1'b0;
          end else tr = 1'b1;
        end
        default: tr = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = tr;
      cur = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      if (pv && !pr)
        chk("hold", {m_axis_tvalid, cur}, {1'b1, pd});
      else if (m_axis_tvalid && need_gap) begin
        chk("gap", idle, gap);
        need_gap = 0; idle = 0;
      end else if (!m_axis_tvalid && need_gap)
        idle++;
      else if (!m_axis_tvalid)
        chk("vdrop", m_axis_tvalid, 1);
      if (m_axis_tvalid && tr) begin
        chk($sformatf("beat%0d", sent), {busy_o, done_o, cur},
            {2'b10, q.pop_front()});
        sent++;
        last_cyc = cyc;
        if (q.size() > 0) need_gap = 1;
      end
      pv = m_axis_tvalid; pr = tr; pd = cur;
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) chk("timeout", q.size(), 0);
    chk("done", {done_o, busy_o, m_axis_tvalid}, 3'b110);
    if (rmode == 0)
      chk("span", last_cyc + 1, total + (total - 1) * int'(gap));
    if (start_in_done) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("idle", {done_o, busy_o, m_axis_tvalid}, 3'b000);
    @(negedge clk);
    chk("idle2", {busy_o, m_axis_tvalid}, 2'b00);
  endtask

  task automatic sink_frame(input int len, inout logic [31:0] sum);
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = (k == len - 1);
      sum = sum + 32'(s_axis_tdata);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sum;
    bit found;
    reset_i = 1'b1; start_i = 1'b0; mode_i = '0; seed_i = '0;
    gap_i = '0; num_frames_i = '0; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_m", {m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                  m_axis_tdata}, '0);
    chk("rst_st", {busy_o, done_o, err_len_o, rx_frames_o}, '0);
    chk("rst_cs", checksum_o, 0);
    chk("rst_rdy", s_axis_tready, 1);

    run_xfer(2'b00, 16'h0, 8'd0, 8'd1, 0, 1);
    run_xfer(2'b00, 16'h0, 8'd0, 8'd1, 1, 0);
    run_xfer(2'b00, 16'h0, 8'd2, 8'd1, 0, 0);
    run_xfer(2'b10, 16'hACE1, 8'd0, 8'd2, 0, 0);
    run_xfer(2'b01, 16'h12A5, 8'd1, 8'd0, 0, 0);
    run_xfer(2'b10, 16'h0, 8'd0, 8'd1, 2, 0);
    run_xfer(2'b11, 16'h0, 8'd3, 8'd2, 2, 0);
    for (int r = 0; r < 6; r++)
      run_xfer(2'($urandom_range(0, 3)), 16'($urandom),
               8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
               2, 0);

    sum = 0;
    sink_frame(16, sum);
    chk("snk1", {err_len_o, rx_frames_o}, {1'b0, 16'd1});
    sink_frame(15, sum);
    chk("snk2", {err_len_o, rx_frames_o}, {1'b1, 16'd2});
    sink_frame(16, sum);
    chk("snk3", {err_len_o, rx_frames_o}, {1'b1, 16'd3});
    chk("csum", checksum_o, sum);
    run_xfer(2'b00, 16'h0, 8'd0, 8'd1, 0, 0);
    chk("snk_keep", {err_len_o, rx_frames_o, checksum_o},
        {1'b1, 16'd3, sum});

    @(negedge clk);
    mode_i = 2'b00; gap_i = 8'd0; num_frames_i = 8'd3;
    m_axis_tready = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_axis_tvalid && m_axis_tdata == 8'd7) found = 1;
      else @(negedge clk);
    end
    chk("rst_wait", found, 1);
    reset_i = 1'b1;
    @(negedge clk);
    chk("mrst_m", {m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                   m_axis_tdata}, '0);
    chk("mrst_st", {busy_o, done_o, err_len_o, rx_frames_o}, '0);
    chk("mrst_cs", checksum_o, 0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("mrst_idle", m_axis_tvalid, 0);
    run_xfer(2'b00, 16'h0, 8'd0, 8'd1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
